// File: rtl/servo_pwm_gen_if.sv
// Servo command/status bundle between the PIO command source and one
// servo_pwm_gen channel.
//   cmd          : [15] enable, [14:11] ignored, [10:0] requested offset (us)
//   servo_pwm    : PWM pin drive
//   frame_start  : one-clock pulse in the first cycle of each frame
//   cur_width    : pulse width (us) currently being generated
//   at_target    : applied offset equals the clamped target while enabled
interface servo_pwm_gen_if;
  logic [15:0] cmd;
  logic        servo_pwm;
  logic        frame_start;
  logic [10:0] cur_width;
  logic        at_target;

  modport master (
    output cmd,
    input  servo_pwm, frame_start, cur_width, at_target
  );

  modport slave (
    input  cmd,
    output servo_pwm, frame_start, cur_width, at_target
  );
endinterface

// File: rtl/servo_pwm_gen.sv
// RC-servo PWM generator. A prescaler makes a microsecond tick; a frame
// counter spans FRAME_US ticks. At each frame boundary the command word is
// sampled, the offset is moved toward the clamped target (slew-limited
// while running, direct jump on the first enabled frame) and a pulse of
// MIN_US+offset us is generated from the start of the frame.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : servo_pwm_gen_if.slave (cmd in; servo_pwm, frame_start,
//              cur_width, at_target out, all registered)
module servo_pwm_gen #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned TICK_HZ  = 1000000,
  parameter int unsigned FRAME_US = 20000,
  parameter int unsigned MIN_US   = 1000,
  parameter int unsigned MAX_US   = 2000,
  parameter int unsigned SLEW_US  = 20
) (
  input  logic            clk,
  input  logic            reset_n,
  servo_pwm_gen_if.slave  bus
);

  localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned SPAN = MAX_US - MIN_US;
  localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned FW   = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_US - 1);
  localparam logic [10:0]   SPAN_W     = 11'(SPAN);
  localparam logic [10:0]   SLEW_W     = 11'(SLEW_US);
  localparam logic [10:0]   OFF_RST    = 11'(SPAN / 2);
  localparam logic [10:0]   WIDTH_RST  = 11'(MIN_US + SPAN / 2);

  typedef enum logic {ST_OFF, ST_RUN} state_t;

  logic [PW-1:0] r_pre;
  logic [FW-1:0] r_us;
  state_t        r_st;
  logic [10:0]   r_off;
  logic [10:0]   r_width;
  logic          r_pwm;
  logic          r_fs;
  logic          r_at;

  logic          w_tick;
  logic          w_bnd;
  logic [FW-1:0] w_us_next;
  logic [10:0]   w_tgt;
  logic [10:0]   w_diff;
  logic [10:0]   w_off_next;
  state_t        w_st_next;
  logic          w_pwm_next;
  logic          w_unused;

  assign w_unused = ^bus.cmd[14:11];

  always_comb begin
    w_tick     = (r_pre == PRE_LAST);
    w_bnd      = w_tick && (r_us == FRAME_LAST);
    w_tgt      = (bus.cmd[10:0] > SPAN_W) ? SPAN_W : bus.cmd[10:0];
    w_us_next  = r_us;
    w_off_next = r_off;
    w_st_next  = r_st;
    w_diff     = '0;

    if (w_tick) begin
      w_us_next = w_bnd ? '0 : r_us + FW'(1);
    end

    if (w_bnd) begin
      unique case (r_st)
        ST_OFF: begin
          if (bus.cmd[15]) begin
            w_st_next  = ST_RUN;
            w_off_next = w_tgt;
          end
        end
        ST_RUN: begin
          if (!bus.cmd[15]) begin
            w_st_next = ST_OFF;
          end else if (w_tgt >= r_off) begin
            // Step is the smaller of the remaining distance and SLEW, so
            // it can neither overshoot nor leave 0..SPAN.
            w_diff     = w_tgt - r_off;
            w_off_next = (SLEW_US == 0 || w_diff <= SLEW_W) ? w_tgt : r_off + SLEW_W;
          end else begin
            w_diff     = r_off - w_tgt;
            w_off_next = (SLEW_US == 0 || w_diff <= SLEW_W) ? w_tgt : r_off - SLEW_W;
          end
        end
        default: w_st_next = ST_OFF;
      endcase
    end

    // Compare against next-cycle counter/offset so the registered pin rises
    // together with frame_start and stays high exactly width*DIV clocks.
    w_pwm_next = (w_st_next == ST_RUN) &&
                 ((32'(w_us_next)) < (MIN_US + 32'(w_off_next)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre   <= '0;
      r_us    <= '0;
      r_st    <= ST_OFF;
      r_off   <= OFF_RST;
      r_width <= WIDTH_RST;
      r_pwm   <= 1'b0;
      r_fs    <= 1'b0;
      r_at    <= 1'b0;
    end else begin
      r_pre   <= w_tick ? '0 : r_pre + PW'(1);
      r_us    <= w_us_next;
      r_st    <= w_st_next;
      r_off   <= w_off_next;
      r_width <= 11'(MIN_US + 32'(w_off_next));
      r_pwm   <= w_pwm_next;
      r_fs    <= w_bnd;
      if (w_bnd) begin
        r_at <= (w_st_next == ST_RUN) && (w_off_next == w_tgt);
      end
    end
  end

  assign bus.servo_pwm   = r_pwm;
  assign bus.frame_start = r_fs;
  assign bus.cur_width   = r_width;
  assign bus.at_target   = r_at;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen using reduced timing (DIV=2, 600 us frame,
// 100..500 us pulse, slew 40 us) so that many frames fit in a short run.
module tb_servo_pwm_gen;

  localparam int CLK_HZ   = 2000000;
  localparam int TICK_HZ  = 1000000;
  localparam int FRAME_US = 600;
  localparam int MIN_US   = 100;
  localparam int MAX_US   = 500;
  localparam int SLEW_US  = 40;
  localparam int DIV      = CLK_HZ / TICK_HZ;
  localparam int SPAN     = MAX_US - MIN_US;
  localparam int FC       = FRAME_US * DIV;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  servo_pwm_gen_if bus ();

  servo_pwm_gen #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .FRAME_US (FRAME_US),
    .MIN_US   (MIN_US),
    .MAX_US   (MAX_US),
    .SLEW_US  (SLEW_US)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: frame position derived from clocks since release.
  int k     = 0;
  bit m_run = 1'b0;
  int m_off = SPAN / 2;
  bit m_at  = 1'b0;

  task automatic model_boundary(input logic [15:0] c);
    int tgt;
    tgt = (int'(c[10:0]) > SPAN) ? SPAN : int'(c[10:0]);
    if (c[15]) begin
      if (!m_run || SLEW_US == 0) m_off = tgt;
      else if (tgt > m_off + SLEW_US) m_off = m_off + SLEW_US;
      else if (tgt < m_off - SLEW_US) m_off = m_off - SLEW_US;
      else m_off = tgt;
      m_run = 1'b1;
    end else begin
      m_run = 1'b0;
    end
    m_at = m_run && (m_off == tgt);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Per-cycle compare process.
  initial begin
    int e_fs, e_pwm, e_w, e_at;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        k = 0; m_run = 1'b0; m_off = SPAN / 2; m_at = 1'b0;
      end else begin
        k++;
        if (k % FC == 0) model_boundary(bus.cmd);
      end
      #1;
      if (!reset_n) begin
        e_fs = 0; e_pwm = 0; e_w = MIN_US + SPAN / 2; e_at = 0;
      end else begin
        e_fs  = (k > 0 && k % FC == 0) ? 1 : 0;
        e_w   = MIN_US + m_off;
        e_pwm = (m_run && (k % FC) < e_w * DIV) ? 1 : 0;
        e_at  = m_at ? 1 : 0;
      end
      chk("cyc frame_start", int'(bus.frame_start), e_fs);
      chk("cyc servo_pwm",   int'(bus.servo_pwm),   e_pwm);
      chk("cyc cur_width",   int'(bus.cur_width),   e_w);
      chk("cyc at_target",   int'(bus.at_target),   e_at);
    end
  end

  task automatic wait_fs(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_start && n < 2 * FC);
    chk({nm, " frame_start seen"}, int'(bus.frame_start), 1);
  endtask

  // Waits for the first frame_start after reset release (called at release).
  task automatic first_fs(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_start && n < 2 * FC);
    chk({nm, " first frame_start clock"}, n, FC);
  endtask

  // Called at the frame_start negedge; ends on the frame's last negedge.
  task automatic frame_body(input int exp_w, input bit exp_on, input bit exp_at,
                            input string nm, input int chg_at, input logic [15:0] chg_val);
    int cnt;
    chk({nm, " cur_width"}, int'(bus.cur_width), exp_w);
    chk({nm, " at_target"}, int'(bus.at_target), int'(exp_at));
    cnt = 0;
    for (int i = 0; i < FC; i++) begin
      if (i == chg_at) bus.cmd = chg_val;
      if (bus.servo_pwm) cnt++;
      if (i < FC - 1) @(negedge clk);
    end
    chk({nm, " pulse clocks"}, cnt, exp_on ? exp_w * DIV : 0);
  endtask

  task automatic frame_check(input int exp_w, input bit exp_on, input bit exp_at,
                             input string nm);
    wait_fs(nm);
    frame_body(exp_w, exp_on, exp_at, nm, -1, 16'h0000);
  endtask

  function automatic logic [15:0] rand_cmd();
    logic [15:0] c;
    c[15]    = ($urandom_range(0, 3) != 0);
    c[14:11] = 4'($urandom_range(0, 15));
    c[10:0]  = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047))
                                          : 11'($urandom_range(0, SPAN));
    return c;
  endfunction

  initial begin
    bus.cmd = 16'h0000;

    // Idle after reset: no pulse, default width.
    repeat (5) @(negedge clk);
    chk("reset servo_pwm", int'(bus.servo_pwm), 0);
    chk("reset cur_width", int'(bus.cur_width), 300);
    reset_n = 1'b1;
    first_fs("idle");
    frame_body(300, 1'b0, 1'b0, "idle0", -1, 16'h0000);
    frame_check(300, 1'b0, 1'b0, "idle1");

    // Enable while OFF: direct jump to offset 250.
    bus.cmd = 16'h80FA;
    frame_check(350, 1'b1, 1'b1, "en_jump");
    frame_check(350, 1'b1, 1'b1, "en_hold");

    // Slew 250 -> 330.
    bus.cmd = 16'h814A;
    frame_check(390, 1'b1, 1'b0, "slew_up1");
    frame_check(430, 1'b1, 1'b1, "slew_up2");

    // Over-range request clamps to SPAN; final step is partial.
    bus.cmd = 16'h87FF;
    frame_check(470, 1'b1, 1'b0, "clamp1");
    frame_check(500, 1'b1, 1'b1, "clamp2");
    frame_check(500, 1'b1, 1'b1, "clamp_hold");

    // Descend to offset 0 without undershoot.
    bus.cmd = 16'h8000;
    for (int i = 1; i <= 10; i++) begin
      frame_check(500 - 40 * i, 1'b1, (i == 10), "descend");
    end
    frame_check(100, 1'b1, 1'b1, "floor_hold");

    // Disable mid-pulse: pulse completes, next frame low, then direct jump.
    wait_fs("mid_clear");
    frame_body(100, 1'b1, 1'b1, "mid_clear", 50, 16'h0000);
    frame_check(100, 1'b0, 1'b0, "off_frame");
    bus.cmd = 16'hF92C;
    frame_check(400, 1'b1, 1'b1, "reenable_jump");

    // Reset asserted mid-pulse drops the pin without a clock edge.
    wait_fs("rst_mid");
    repeat (100) @(negedge clk);
    chk("pre_reset servo_pwm", int'(bus.servo_pwm), 1);
    bus.cmd = 16'h815E;
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset servo_pwm", int'(bus.servo_pwm), 0);
    chk("async_reset cur_width", int'(bus.cur_width), 300);
    chk("async_reset at_target", int'(bus.at_target), 0);
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    first_fs("post_reset");
    frame_body(450, 1'b1, 1'b1, "post_reset_jump", -1, 16'h0000);

    // Random commands, changing at arbitrary points inside frames.
    for (int f = 0; f < 8; f++) begin
      wait_fs("rand");
      for (int i = 0; i < FC - 1; i++) begin
        if ($urandom_range(0, 299) == 0) bus.cmd = rand_cmd();
        @(negedge clk);
      end
      if ($urandom_range(0, 1) == 0) bus.cmd = rand_cmd();
    end
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
